earendel_shiftreg_top: RTL and testbench

EARENDEL_SHIFTREG_TOP -- requirements
Module: earendel_shiftreg_top

---
 rtl/earendel_shiftreg_top.sv | 125 ++++++++++++
 tb/tb_earendel_shiftreg_top.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/earendel_shiftreg_top.sv
// earendel_shiftreg_top: repeating serial frame generator (idle gap, start bit, words MSB first, optional parity, stop bit)
// Ports: CLK - system clock, all state changes on its rising edge
//        RST - synchronous active-high reset, aborts any frame in progress
//        SDO_signal_out - registered serial data out, idles at 1
// Optional feature: define PARITY_EN to follow each word with an even-parity bit.
module earendel_shiftreg_top #(
    parameter int DATA_W    = 16,
    parameter int NUM_WORDS = 4,
    parameter int DIV       = 4,
    parameter int GAP       = 8,
    parameter logic [DATA_W-1:0] WORD0 = 16'hA5C3,
    parameter logic [DATA_W-1:0] WORD1 = 16'h0F0F,
    parameter logic [DATA_W-1:0] WORD2 = 16'h1234,
    parameter logic [DATA_W-1:0] WORD3 = 16'h8007,
    parameter logic [DATA_W-1:0] WORD4 = '0,
    parameter logic [DATA_W-1:0] WORD5 = '0,
    parameter logic [DATA_W-1:0] WORD6 = '0,
    parameter logic [DATA_W-1:0] WORD7 = '0
) (
    input  logic CLK,
    input  logic RST,
    output logic SDO_signal_out
);
    localparam int DCW = $clog2(DIV);
    localparam int GCW = $clog2(GAP + 1);
    localparam int BCW = $clog2(DATA_W + 1);
    localparam logic [DATA_W-1:0] WORDS [8] = '{WORD0, WORD1, WORD2, WORD3, WORD4, WORD5, WORD6, WORD7};
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] STOP  = 3'd3;
`ifdef PARITY_EN
    localparam logic [2:0] PAR   = 3'd4;
`endif
    logic [2:0]        state;
    logic [DCW-1:0]    div_cnt;
    logic [GCW-1:0]    gap_cnt;
    logic [BCW-1:0]    bit_cnt;
    logic [2:0]        word_idx;
    logic [DATA_W-1:0] sh;
    logic              tick;
    logic              word_done;
    logic              last_word;
    logic [2:0]        nxt_idx;
    logic [DATA_W-1:0] nxt_word;
    always_comb begin
        tick      = div_cnt == DCW'(DIV - 1);
        last_word = word_idx == 3'(NUM_WORDS - 1);
        nxt_idx   = word_idx + 3'd1;
        nxt_word  = WORDS[nxt_idx];
        // A word is finished once its last serial bit (LSB, or parity when enabled) has had its bit-time.
`ifdef PARITY_EN
        word_done = tick && state == PAR;
`else
        word_done = tick && state == DATA && bit_cnt == BCW'(DATA_W - 1);
`endif
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            state          <= IDLE;
            div_cnt        <= '0;
            gap_cnt        <= '0;
            bit_cnt        <= '0;
            word_idx       <= '0;
            sh             <= '0;
            SDO_signal_out <= 1'b1;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick) begin
                case (state)
                    IDLE: begin
                        gap_cnt <= gap_cnt == GCW'(GAP - 1) ? '0 : gap_cnt + 1'b1;
                        if (gap_cnt == GCW'(GAP - 1)) begin
                            state          <= START;
                            SDO_signal_out <= 1'b0;
                        end
                    end
                    START: begin
                        state          <= DATA;
                        bit_cnt        <= '0;
                        SDO_signal_out <= WORDS[0][DATA_W-1];
                        sh             <= WORDS[0] << 1;
                    end
                    DATA: begin
                        if (bit_cnt != BCW'(DATA_W - 1)) begin
                            bit_cnt        <= bit_cnt + 1'b1;
                            SDO_signal_out <= sh[DATA_W-1];
                            sh             <= sh << 1;
                        end else begin
                            bit_cnt <= '0;
`ifdef PARITY_EN
                            state          <= PAR;
                            SDO_signal_out <= ^WORDS[word_idx];
`endif
                        end
                    end
`ifdef PARITY_EN
                    PAR: ;
`endif
                    STOP: begin
                        state          <= IDLE;
                        SDO_signal_out <= 1'b1;
                    end
                    default: begin
                        state          <= IDLE;
                        SDO_signal_out <= 1'b1;
                    end
                endcase
                // Word boundary: either close the frame or launch the next word's MSB with no gap.
                if (word_done) begin
                    if (last_word) begin
                        state          <= STOP;
                        word_idx       <= '0;
                        SDO_signal_out <= 1'b1;
                    end else begin
                        state          <= DATA;
                        word_idx       <= nxt_idx;
                        SDO_signal_out <= nxt_word[DATA_W-1];
                        sh             <= nxt_word << 1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_earendel_shiftreg_top.sv
// tb_earendel_shiftreg_top: self-checking bench comparing the serial stream against a bit-pattern model
module tb_earendel_shiftreg_top;
    typedef bit q_t[$];
    typedef logic [15:0] w8_t [8];
    localparam int D1 = 4;
    localparam int G1 = 8;
    localparam int D2 = 2;
    localparam int G2 = 1;
`ifdef PARITY_EN
    localparam int PB   = 1;
    localparam int PER1 = 312;
    localparam int PER2 = 40;
`else
    localparam int PB   = 0;
    localparam int PER1 = 296;
    localparam int PER2 = 38;
`endif
    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic sdo1;
    logic sdo2;
    int tests = 0;
    int fails = 0;
    q_t q1;
    q_t q2;
    w8_t w1 = '{16'hA5C3, 16'h0F0F, 16'h1234, 16'h8007, 16'h0, 16'h0, 16'h0, 16'h0};
    w8_t w2 = '{16'h0001, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    earendel_shiftreg_top dut (.CLK(CLK), .RST(RST), .SDO_signal_out(sdo1));
    earendel_shiftreg_top #(.DIV(2), .GAP(1), .NUM_WORDS(1), .WORD0(16'h0001)) dut2 (.CLK(CLK), .RST(RST), .SDO_signal_out(sdo2));
    always #5 CLK = ~CLK;
    // One repetition of the line, one entry per bit-time, starting at reset release.
    function automatic q_t build(int gap, int nw, w8_t w);
        q_t q;
        for (int i = 0; i < gap; i++) q.push_back(1'b1);
        q.push_back(1'b0);
        for (int j = 0; j < nw; j++) begin
            for (int b = 15; b >= 0; b--) q.push_back(w[j][b]);
`ifdef PARITY_EN
            q.push_back(^w[j]);
`endif
        end
        q.push_back(1'b1);
        return q;
    endfunction
    function automatic bit exp1(int n);
        return q1[(n / D1) % q1.size()];
    endfunction
    function automatic bit exp2(int n);
        return q2[(n / D2) % q2.size()];
    endfunction
    task automatic do_reset(int hold);
        @(negedge CLK);
        RST = 1'b1;
        repeat (hold) @(negedge CLK);
        RST = 1'b0;
    endtask
    task automatic test_reset;
        @(negedge CLK);
        RST = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            tests += 2;
            if (sdo1 !== 1'b1) begin fails++; $display("FAIL reset_hold dut cyc=%0d got=%b exp=1", i, sdo1); end
            if (sdo2 !== 1'b1) begin fails++; $display("FAIL reset_hold dut2 cyc=%0d got=%b exp=1", i, sdo2); end
        end
        RST = 1'b0;
        for (int n = 1; n <= 35; n++) begin
            @(negedge CLK);
            tests++;
            if (sdo1 !== (n >= 32 ? 1'b0 : 1'b1)) begin
                fails++;
                $display("FAIL first_start edge=%0d got=%b exp=%b", n, sdo1, n >= 32 ? 1'b0 : 1'b1);
            end
        end
    endtask
    task automatic test_frame;
        bit samp[$];
        logic [15:0] wexp [4] = '{16'hA5C3, 16'h0F0F, 16'h1234, 16'h8007};
        logic [15:0] got;
        int sp;
`ifdef PARITY_EN
        bit pexp [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
`endif
        do_reset(3);
        for (int n = 1; n <= 2 * PER1 + 16; n++) begin
            @(negedge CLK);
            tests += 2;
            if (sdo1 !== exp1(n)) begin fails++; $display("FAIL frame dut edge=%0d got=%b exp=%b", n, sdo1, exp1(n)); end
            if (sdo2 !== exp2(n)) begin fails++; $display("FAIL frame dut2 edge=%0d got=%b exp=%b", n, sdo2, exp2(n)); end
            if (n % D1 == D1 / 2) samp.push_back(sdo1);
        end
        tests++;
        if (samp[G1] !== 1'b0) begin fails++; $display("FAIL start_bit got=%b exp=0", samp[G1]); end
        for (int j = 0; j < 4; j++) begin
            got = '0;
            for (int b = 0; b < 16; b++) got = {got[14:0], logic'(samp[G1 + 1 + j * (16 + PB) + b])};
            tests++;
            if (got !== wexp[j]) begin fails++; $display("FAIL word%0d got=%h exp=%h", j, got, wexp[j]); end
`ifdef PARITY_EN
            tests++;
            if (samp[G1 + 1 + j * 17 + 16] !== pexp[j]) begin
                fails++;
                $display("FAIL parity%0d got=%b exp=%b", j, samp[G1 + 1 + j * 17 + 16], pexp[j]);
            end
`endif
        end
        sp = G1 + 1 + 4 * (16 + PB);
        for (int k = 0; k <= G1; k++) begin
            tests++;
            if (samp[sp + k] !== 1'b1) begin fails++; $display("FAIL stop_idle bit=%0d got=%b exp=1", k, samp[sp + k]); end
        end
        tests++;
        if (samp[sp + G1 + 1] !== 1'b0) begin fails++; $display("FAIL next_start got=%b exp=0", samp[sp + G1 + 1]); end
    endtask
    task automatic test_period;
        int f1[$];
        int f2[$];
        int hr1 = 0;
        int hr2 = 0;
        logic p1 = 1'b1;
        logic p2 = 1'b1;
        do_reset(2);
        for (int c = 1; c <= 1500; c++) begin
            @(negedge CLK);
            if (p1 && !sdo1 && hr1 >= G1 * D1) f1.push_back(c);
            if (p2 && !sdo2 && hr2 >= G2 * D2) f2.push_back(c);
            hr1 = sdo1 ? hr1 + 1 : 0;
            hr2 = sdo2 ? hr2 + 1 : 0;
            p1 = sdo1;
            p2 = sdo2;
            if (f1.size() >= 2 && f2.size() >= 2) break;
        end
        tests += 2;
        if (f1.size() < 2) begin fails++; $display("FAIL period dut timeout starts=%0d exp=2", f1.size()); end
        else if (f1[1] - f1[0] != PER1) begin fails++; $display("FAIL period dut got=%0d exp=%0d", f1[1] - f1[0], PER1); end
        if (f2.size() < 2) begin fails++; $display("FAIL period dut2 timeout starts=%0d exp=2", f2.size()); end
        else if (f2[1] - f2[0] != PER2) begin fails++; $display("FAIL period dut2 got=%0d exp=%0d", f2[1] - f2[0], PER2); end
    endtask
    task automatic test_mid_reset;
        int stop_n;
        do_reset(1);
        stop_n = (G1 + 1 + 2 * (16 + PB)) * D1 + int'($urandom_range(0, 16 * D1 - 1));
        for (int n = 1; n <= stop_n; n++) begin
            @(negedge CLK);
            tests++;
            if (sdo1 !== exp1(n)) begin fails++; $display("FAIL pre_abort edge=%0d got=%b exp=%b", n, sdo1, exp1(n)); end
        end
        RST = 1'b1;
        @(negedge CLK);
        tests++;
        if (sdo1 !== 1'b1) begin fails++; $display("FAIL abort at=%0d got=%b exp=1", stop_n, sdo1); end
        RST = 1'b0;
        for (int n = 1; n <= PER1 + 40; n++) begin
            @(negedge CLK);
            tests++;
            if (sdo1 !== exp1(n)) begin fails++; $display("FAIL post_abort edge=%0d got=%b exp=%b", n, sdo1, exp1(n)); end
        end
    endtask
    task automatic test_random_reset;
        int hold;
        int run;
        for (int it = 0; it < 4; it++) begin
            hold = int'($urandom_range(1, 4));
            run  = int'($urandom_range(1, 700));
            do_reset(hold);
            for (int n = 1; n <= run; n++) begin
                @(negedge CLK);
                tests += 2;
                if (sdo1 !== exp1(n)) begin fails++; $display("FAIL rand_reset it=%0d dut edge=%0d got=%b exp=%b", it, n, sdo1, exp1(n)); end
                if (sdo2 !== exp2(n)) begin fails++; $display("FAIL rand_reset it=%0d dut2 edge=%0d got=%b exp=%b", it, n, sdo2, exp2(n)); end
            end
        end
    endtask
    initial begin
        q1 = build(G1, 4, w1);
        q2 = build(G2, 1, w2);
        test_reset();
        test_frame();
        test_period();
        test_mid_reset();
        test_random_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
